// File: rtl/preproc_sched_if.sv
// -----------------------------------------------------------------------------
// preproc_sched_if
//   Bundles every handshake and data signal of the preproc_sched scheduler.
//   The signals fall into three groups:
//     - channel side:    ch_enable, ch_in_valid, ch_in_data, ch_in_ready
//     - normalizer side: norm_in_valid, norm_in_ready, norm_data_in,
//                        norm_out_valid, norm_out_ready, norm_data_out,
//                        norm_shift_amt
//     - downstream side: out_valid, out_ready, out_data, out_shift, out_ch,
//                        plus the busy and timeout_err status outputs
//   Modports:
//     master : the scheduler's view of the signals
//     slave  : the surrounding environment (channels, normalizer, sink)
// -----------------------------------------------------------------------------
interface preproc_sched_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CH      = 4,
  parameter int CH_WIDTH    = $clog2(NUM_CH),
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
);
  // channel side
  logic [NUM_CH-1:0]            ch_enable;
  logic [NUM_CH-1:0]            ch_in_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_in_data;
  logic [NUM_CH-1:0]            ch_in_ready;

  // normalizer side
  logic                         norm_in_valid;
  logic                         norm_in_ready;
  logic [DATA_WIDTH-1:0]        norm_data_in;
  logic                         norm_out_valid;
  logic                         norm_out_ready;
  logic [DATA_WIDTH-1:0]        norm_data_out;
  logic [SHIFT_WIDTH-1:0]       norm_shift_amt;

  // downstream side and status
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [SHIFT_WIDTH-1:0]       out_shift;
  logic [CH_WIDTH-1:0]          out_ch;
  logic                         busy;
  logic                         timeout_err;

  modport master (
    input  ch_enable, ch_in_valid, ch_in_data,
    input  norm_in_ready, norm_out_valid, norm_data_out, norm_shift_amt,
    input  out_ready,
    output ch_in_ready,
    output norm_in_valid, norm_data_in, norm_out_ready,
    output out_valid, out_data, out_shift, out_ch, busy, timeout_err
  );

  modport slave (
    output ch_enable, ch_in_valid, ch_in_data,
    output norm_in_ready, norm_out_valid, norm_data_out, norm_shift_amt,
    output out_ready,
    input  ch_in_ready,
    input  norm_in_valid, norm_data_in, norm_out_ready,
    input  out_valid, out_data, out_shift, out_ch, busy, timeout_err
  );
endinterface

// File: rtl/preproc_sched.sv
// -----------------------------------------------------------------------------
// preproc_sched
//   Round-robin scheduler that shares one sample normalizer among NUM_CH
//   receive channels. Exactly one sample is in flight at a time:
//     IDLE    -> pick the next requesting channel, accept its sample
//     ISSUE   -> present the sample to the normalizer
//     WAIT    -> wait for the normalized result (watchdog-guarded)
//     DELIVER -> present result + shift + channel index downstream
//   A normalizer that never answers is abandoned after TIMEOUT WAIT cycles;
//   timeout_err then stays set until reset.
//
// Ports
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : preproc_sched_if.master carrying the channel, normalizer and
//              downstream handshakes plus busy/timeout_err
// -----------------------------------------------------------------------------
module preproc_sched #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CH      = 4,
  parameter int CH_WIDTH    = $clog2(NUM_CH),
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
  parameter int TIMEOUT     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  preproc_sched_if.master  bus
);

  localparam int WD_WIDTH = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DELIVER
  } state_e;

  state_e                  state_q,       state_d;
  logic [CH_WIDTH-1:0]     rr_ptr_q,      rr_ptr_d;
  logic [CH_WIDTH-1:0]     grant_ch_q,    grant_ch_d;
  logic [DATA_WIDTH-1:0]   hold_data_q,   hold_data_d;
  logic [WD_WIDTH-1:0]     wdog_q,        wdog_d;
  logic [DATA_WIDTH-1:0]   out_data_q,    out_data_d;
  logic [SHIFT_WIDTH-1:0]  out_shift_q,   out_shift_d;
  logic [CH_WIDTH-1:0]     out_ch_q,      out_ch_d;
  logic                    timeout_err_q, timeout_err_d;

  logic [NUM_CH-1:0]       req;
  logic [CH_WIDTH-1:0]     winner;
  logic                    found;
  logic [CH_WIDTH-1:0]     next_ptr;
  logic [CH_WIDTH:0]       cand;

  assign req = bus.ch_in_valid & bus.ch_enable;

  // Channel after the current grant, wrapping for any NUM_CH (not only 2^n).
  assign next_ptr = (grant_ch_q == CH_WIDTH'(NUM_CH - 1)) ? '0
                                                          : grant_ch_q + 1'b1;

  // Round-robin pick: first requesting channel at or after rr_ptr, wrapping.
  // NOTE: every signal written in an always_comb gets a default on entry, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr_ptr_q} + (CH_WIDTH+1)'(i);
      if (cand >= (CH_WIDTH+1)'(NUM_CH)) begin
        cand = cand - (CH_WIDTH+1)'(NUM_CH);
      end
      if (!found && req[cand[CH_WIDTH-1:0]]) begin
        found  = 1'b1;
        winner = cand[CH_WIDTH-1:0];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_ch_d     = grant_ch_q;
    hold_data_d    = hold_data_q;
    wdog_d         = wdog_q;
    out_data_d     = out_data_q;
    out_shift_d    = out_shift_q;
    out_ch_d       = out_ch_q;
    timeout_err_d  = timeout_err_q;

    bus.ch_in_ready    = '0;
    bus.norm_in_valid  = 1'b0;
    bus.norm_out_ready = 1'b0;
    bus.out_valid      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // ch_enable is only looked at here; a channel disabled later still
        // completes its transaction.
        if (found) begin
          bus.ch_in_ready[winner] = 1'b1;
          grant_ch_d  = winner;
          hold_data_d = bus.ch_in_data[winner*DATA_WIDTH +: DATA_WIDTH];
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
        bus.norm_in_valid = 1'b1;
        if (bus.norm_in_ready) begin
          wdog_d  = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // Held for the whole state: the result may be a one-cycle pulse.
        bus.norm_out_ready = 1'b1;
        if (bus.norm_out_valid) begin
          // A result on the watchdog's final cycle still counts as a result.
          out_data_d  = bus.norm_data_out;
          out_shift_d = bus.norm_shift_amt;
          out_ch_d    = grant_ch_q;
          state_d     = S_DELIVER;
        end else if (wdog_q == WD_WIDTH'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          rr_ptr_d      = next_ptr;
          state_d       = S_IDLE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      S_DELIVER: begin
        // out_* come straight from flops that only load in WAIT, so they
        // are stable while downstream stalls.
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          rr_ptr_d = next_ptr;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: the sample holding register is reset too, so nothing of a dropped
  // sample survives a reset and simulation never starts from X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      grant_ch_q    <= '0;
      hold_data_q   <= '0;
      wdog_q        <= '0;
      out_data_q    <= '0;
      out_shift_q   <= '0;
      out_ch_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_ch_q    <= grant_ch_d;
      hold_data_q   <= hold_data_d;
      wdog_q        <= wdog_d;
      out_data_q    <= out_data_d;
      out_shift_q   <= out_shift_d;
      out_ch_q      <= out_ch_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.norm_data_in = hold_data_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_shift    = out_shift_q;
  assign bus.out_ch       = out_ch_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_preproc_sched.sv
// -----------------------------------------------------------------------------
// tb_preproc_sched
//   Directed bench for preproc_sched. The bench plays the channels, the
//   normalizer (returning hand-computed normalized values) and the sink.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_preproc_sched;

  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int SHW = 4;
  localparam int TO  = 32;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  preproc_sched_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

  preproc_sched #(
    .DATA_WIDTH(DW),
    .NUM_CH    (NCH),
    .TIMEOUT   (TO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Hand-computed normalizer vectors: sample, normalized sample, left shift.
  logic [DW-1:0]  nin  [NCH] = '{16'h0001, 16'h0300, 16'h1234, 16'h8001};
  logic [DW-1:0]  nout [NCH] = '{16'h8000, 16'hC000, 16'h91A0, 16'h8001};
  logic [SHW-1:0] nsh  [NCH] = '{4'd15,    4'd6,     4'd3,     4'd0};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle_inputs();
    bus.ch_enable      = '0;
    bus.ch_in_valid    = '0;
    bus.ch_in_data     = {nin[3], nin[2], nin[1], nin[0]};
    bus.norm_in_ready  = 1'b1;
    bus.norm_out_valid = 1'b0;
    bus.norm_data_out  = '0;
    bus.norm_shift_amt = '0;
    bus.out_ready      = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive_idle_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One full transaction for channel c: grant, issue, wait lat extra cycles,
  // result, then bp cycles of downstream stall (0 = immediate accept).
  task automatic serve(input int c, input int lat, input int bp);
    int n;
    #1;
    n = 0;
    while (bus.ch_in_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant", 64'(bus.ch_in_ready), 64'(4'b0001 << c));
    @(negedge clk);
    check("issue", {bus.norm_in_valid, bus.norm_data_in}, {1'b1, nin[c]});
    @(negedge clk);
    check("wait", {bus.norm_out_ready, bus.out_valid, bus.ch_in_ready},
          {1'b1, 1'b0, 4'b0000});
    repeat (lat) @(negedge clk);
    if (bp > 0) bus.out_ready = 1'b0;
    bus.norm_out_valid = 1'b1;
    bus.norm_data_out  = nout[c];
    bus.norm_shift_amt = nsh[c];
    @(negedge clk);
    bus.norm_out_valid = 1'b0;
    bus.norm_data_out  = '0;
    bus.norm_shift_amt = '0;
    check("deliver", {bus.out_valid, bus.out_data, bus.out_shift, bus.out_ch},
          {1'b1, nout[c], nsh[c], 2'(c)});
    for (int k = 1; k < bp; k++) begin
      @(negedge clk);
      check("stall_hold",
            {bus.out_valid, bus.out_data, bus.out_shift, bus.out_ch,
             bus.ch_in_ready, bus.norm_out_ready, bus.norm_in_valid},
            {1'b1, nout[c], nsh[c], 2'(c), 4'b0000, 1'b0, 1'b0});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("busy_after", 64'(bus.busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int cnt;
    logic seen_out;

    reset_n = 1'b0;
    drive_idle_inputs();
    #3;
    check("rst_ctrl",
          {bus.busy, bus.out_valid, bus.timeout_err, bus.norm_in_valid,
           bus.norm_out_ready, bus.ch_in_ready}, 64'(0));
    check("rst_out", {bus.out_data, bus.out_shift, bus.out_ch}, 64'(0));
    do_reset();

    // Single channel: 0x0001 -> 0x8000, shift 15.
    bus.ch_enable   = 4'b0001;
    bus.ch_in_valid = 4'b0001;
    serve(0, 2, 0);
    bus.ch_in_valid = 4'b0000;

    // Round-robin fairness with every channel requesting.
    do_reset();
    bus.ch_enable   = 4'b1111;
    bus.ch_in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) serve(k % NCH, 1, 0);

    // Masking and wrap; the last result lands on the watchdog's final cycle.
    do_reset();
    bus.ch_enable   = 4'b1010;
    bus.ch_in_valid = 4'b1111;
    serve(1, 0, 0);
    serve(3, 0, 0);
    serve(1, 0, 0);
    serve(3, TO - 1, 0);
    check("no_err_on_edge", 64'(bus.timeout_err), 64'(0));

    // Downstream backpressure for 10 cycles.
    do_reset();
    bus.ch_enable   = 4'b0100;
    bus.ch_in_valid = 4'b1111;
    serve(2, 0, 10);

    // Watchdog: normalizer never answers for channel 0.
    do_reset();
    bus.ch_enable   = 4'b1111;
    bus.ch_in_valid = 4'b1111;
    #1;
    check("wd_grant", 64'(bus.ch_in_ready), 64'(4'b0001));
    @(negedge clk);
    check("wd_issue", 64'(bus.norm_in_valid), 64'(1));
    @(negedge clk);
    cnt      = 0;
    seen_out = 1'b0;
    while (bus.busy && bus.norm_out_ready && cnt < 2*TO) begin
      if (bus.out_valid) seen_out = 1'b1;
      cnt++;
      @(negedge clk);
    end
    check("wd_wait_cycles", 64'(cnt), 64'(TO));
    check("wd_no_out", 64'(seen_out), 64'(0));
    #1;
    check("wd_err_idle", {bus.timeout_err, bus.busy, bus.out_valid,
          bus.ch_in_ready}, {1'b1, 1'b0, 1'b0, 4'b0010});
    serve(1, 0, 0);
    check("wd_err_sticky", 64'(bus.timeout_err), 64'(1));

    // Asynchronous reset while waiting on the normalizer.
    do_reset();
    bus.ch_enable   = 4'b1111;
    bus.ch_in_valid = 4'b0010;
    serve(1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_wait", {bus.busy, bus.norm_out_ready}, 2'b11);
    bus.ch_in_valid = 4'b0000;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ctrl",
          {bus.busy, bus.out_valid, bus.timeout_err, bus.norm_in_valid,
           bus.norm_out_ready, bus.ch_in_ready}, 64'(0));
    check("mid_rst_out", {bus.out_data, bus.out_shift, bus.out_ch}, 64'(0));
    @(negedge clk);
    reset_n         = 1'b1;
    bus.ch_in_valid = 4'b1111;
    serve(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/preproc_sched.md
# preproc_sched

Round-robin scheduler that shares a single sample normalizer (zero-pad, leading-one detect, left-shift) among `NUM_CH` receive channels. It accepts one sample at a time from the granted channel and issues it to the normalizer. It then captures the normalized result and shift amount and presents them downstream tagged with the channel index. A watchdog recovers from a normalizer that never returns a result.

## Interface

Parameters:

- `DATA_WIDTH`, 16: sample width.
- `NUM_CH`, 4: number of requesting channels, ≥2.
- `CH_WIDTH`, `$clog2(NUM_CH)`: channel index width.
- `SHIFT_WIDTH`, `$clog2(DATA_WIDTH)`: shift-amount width.
- `TIMEOUT`, 32: maximum WAIT cycles before abort, ≥8.

Ports:

- `clk` input 1: clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `ch_enable` input NUM_CH: per-channel enable mask.
- `ch_in_valid` input NUM_CH: per-channel sample valid.
- `ch_in_data` input NUM_CH*DATA_WIDTH: channel k in bits [k*DATA_WIDTH +: DATA_WIDTH].
- `ch_in_ready` output NUM_CH: one-hot accept strobe.
- `norm_in_valid` output 1: sample to normalizer valid.
- `norm_in_ready` input 1: normalizer can accept.
- `norm_data_in` output DATA_WIDTH: sample to normalizer.
- `norm_out_valid` input 1: normalizer result valid (may be a single-cycle pulse).
- `norm_out_ready` output 1: scheduler can take a result.
- `norm_data_out` input DATA_WIDTH: normalized sample.
- `norm_shift_amt` input SHIFT_WIDTH: shift applied.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts.
- `out_data` output DATA_WIDTH: normalized sample.
- `out_shift` output SHIFT_WIDTH: shift amount.
- `out_ch` output CH_WIDTH: originating channel.
- `busy` output 1: state ≠ IDLE.
- `timeout_err` output 1: sticky; set on watchdog abort, cleared only by reset.

## Operation

The block has four states: IDLE, ISSUE, WAIT, DELIVER.

- **Request vector:** `req = ch_in_valid & ch_enable`.
- **IDLE:**
  - Winner = first set bit of `req` at index ≥ `rr_ptr`, wrapping to 0.
  - `ch_in_ready[winner]` is driven combinationally high in IDLE when `req` ≠ 0. All other bits are 0.
  - On that edge the block latches the winner's data into `hold_data`, the winner index into `grant_ch`, and moves to ISSUE.
- **ISSUE:**
  - `norm_in_valid=1`, `norm_data_in=hold_data`.
  - When `norm_in_ready=1`, the transfer completes, the watchdog clears, and the block moves to WAIT.
- **WAIT:**
  - `norm_out_ready=1` for the whole state, because the normalizer's result pulse can last one cycle.
  - When `norm_out_valid=1`, the block latches `out_data`/`out_shift` from the normalizer, sets `out_ch=grant_ch`, and moves to DELIVER.
  - The watchdog increments each WAIT cycle. If it reaches `TIMEOUT-1` with no result, the block sets `timeout_err`, discards the sample, sets `rr_ptr=grant_ch+1` (mod NUM_CH), and returns to IDLE.
- **DELIVER:**
  - `out_valid=1` and the outputs are held stable.
  - On `out_ready=1`, `rr_ptr` becomes `grant_ch+1` (mod NUM_CH; `NUM_CH-1` wraps to 0) and the block returns to IDLE.
- **Outstanding transactions:** at most one sample is in flight at any time.
- **Enable mask:** `ch_enable` is sampled only in IDLE. Deasserting an enable mid-transaction does not abort the transaction.
- **Outside their states:** `norm_in_valid`, `norm_out_ready` and `out_valid` are 0, and `ch_in_ready` is all 0.

## Timing

- **Reset (asynchronous, on `reset_n=0`):**
  - State becomes IDLE; `rr_ptr`, `grant_ch`, `hold_data` and the watchdog become 0.
  - `out_valid`, `out_data`, `out_shift`, `out_ch` and `timeout_err` become 0, and `busy=0`.
  - Reset mid-transaction drops the sample without any downstream beat.
  - Deassertion takes effect at the first rising edge after `reset_n` goes high.
- **Accept to issue:** a sample accepted at edge N has `norm_in_valid` high from N+1.
- **Minimum end-to-end latency:**
  - 1 cycle ISSUE (normalizer ready) + normalizer latency in WAIT + result latched.
  - `out_valid` rises the cycle after the `norm_out_valid` cycle.
- **Back-to-back requests:** a new channel is accepted one cycle after the DELIVER handshake, since IDLE lasts at least 1 cycle.
- **Output stability:** `out_*` must not change while `out_valid=1 && out_ready=0`.
- **Simultaneous events:**
  - A result arriving on the same cycle the watchdog hits `TIMEOUT-1` is taken as a result. No error is raised.
  - `out_ready` held high during DELIVER completes the handshake in 1 cycle.
- **Starvation bound:** with all channels requesting, every enabled channel is served within NUM_CH transactions.

## Test plan

- **Single channel:** `ch_enable=4'b0001`, channel 0 sends 16'h0001. The normalizer model returns 16'h8000 with shift 15. Required: `out_data=16'h8000`, `out_shift=15`, `out_ch=0`, `busy` falls after the handshake.
- **Round-robin fairness:** all 4 channels continuously valid with distinct data, `out_ready=1`. Required: `out_ch` sequence 0,1,2,3,0,1,… and each `ch_in_ready` pulse one-hot.
- **Masking and wrap:** `ch_enable=4'b1010`, all valid, `rr_ptr` starting at 0. Required: grants 1,3,1,3. Channels 0 and 2 never see `ch_in_ready`.
- **Backpressure:** hold `out_ready=0` for 10 cycles in DELIVER. Required: `out_*` stable, no new `ch_in_ready`, `norm_out_ready=0`. Releasing `out_ready` completes the handshake.
- **Watchdog:** the normalizer never asserts `norm_out_valid`. Required: return to IDLE after `TIMEOUT` WAIT cycles, `timeout_err=1` (sticky), no `out_valid`, next grant goes to `grant_ch+1`.
- **Reset mid-WAIT:** pull `reset_n` low asynchronously between clock edges. Required: all outputs are 0 immediately, and after release the next transaction starts from channel 0.
